// File: rtl/clb_param_if.sv
// clb_param_if: signal bundle between a configurable logic block and its driver.
//
// Signals:
//   I        LUT inputs, LUT_K bits per BLE (BLE i uses I[i*LUT_K +: LUT_K])
//   CFG_EN   shift-enable for the serial configuration chain
//   CFG_DIN  serial configuration data in
//   CFG_DOUT serial configuration data out (tail of the chain, for daisy-chaining)
//   CFG_DONE high while the block holds a complete configuration
//   X        BLE outputs
//   state    debug view of the configuration FSM state
//
// Handshake: there is no valid/ready pair. CFG_EN is the sole qualifier: every
// rising clock edge with CFG_EN=1 consumes exactly one CFG_DIN bit, and the
// block can always accept it (no back-pressure). CFG_EN=0 means no transfer.
//
// Modports: master drives I/CFG_EN/CFG_DIN; slave (the CLB) drives the rest.
interface clb_param_if #(
  parameter int N_BLE = 2,
  parameter int LUT_K = 4
);
  logic [N_BLE*LUT_K-1:0] I;
  logic                   CFG_EN;
  logic                   CFG_DIN;
  logic                   CFG_DOUT;
  logic                   CFG_DONE;
  logic [N_BLE-1:0]       X;
  logic [1:0]             state;

  modport master (
    output I, CFG_EN, CFG_DIN,
    input  CFG_DOUT, CFG_DONE, X, state
  );

  modport slave (
    input  I, CFG_EN, CFG_DIN,
    output CFG_DOUT, CFG_DONE, X, state
  );
endinterface

// File: rtl/clb_param.sv
// clb_param: parametrised configurable logic block with N_BLE basic logic
// elements. Each BLE has a LUT_K-input LUT, a state bit Q and an output mux.
// Configuration is loaded serially through a shift chain clocked by K.
//
// Ports:
//   K     clock, all state updates on the rising edge
//   RSTN  asynchronous active-low reset
//   bus   clb_param_if.slave (I, CFG_EN, CFG_DIN in; CFG_DOUT, CFG_DONE, X,
//         state out)
//
// Per-BLE config field (BLE i at base b = i*W, LSB first):
//   [b +: 2^LUT_K] LUT contents, then OUTSEL, FBSEL, INIT, LATCH.
//
// Optional feature macro: CLB_LATCH_EN. When defined, a BLE whose LATCH bit is
// set uses a level-sensitive Q (transparent while K=1 and configured). When
// undefined, the LATCH bit keeps its slot in the bitstream but is ignored.
module clb_param #(
  parameter int N_BLE = 2,
  parameter int LUT_K = 4
) (
  input  logic        K,
  input  logic        RSTN,
  clb_param_if.slave  bus
);
  localparam int LUT_N      = 1 << LUT_K;
  localparam int W          = LUT_N + 4;
  localparam int CFG_BITS   = N_BLE * W;
  localparam int CW         = $clog2(CFG_BITS + 1);
  localparam int OFS_OUTSEL = LUT_N;
  localparam int OFS_FBSEL  = LUT_N + 1;
  localparam int OFS_INIT   = LUT_N + 2;
`ifdef CLB_LATCH_EN
  localparam int OFS_LATCH  = LUT_N + 3;
`endif

  typedef enum logic [1:0] {
    UNCFG      = 2'd0,
    LOADING    = 2'd1,
    CONFIGURED = 2'd2
  } state_t;

  state_t              state;
  logic [CFG_BITS-1:0] cfg_sr;
  logic [CFG_BITS-1:0] sr_next;
  logic [CW-1:0]       count;
  logic [N_BLE-1:0]    q;
  logic [N_BLE-1:0]    lut;
  logic [N_BLE-1:0]    q_eff;
  logic [N_BLE-1:0]    init_next;

  assign sr_next = {bus.CFG_DIN, cfg_sr[CFG_BITS-1:1]};

  // INIT bits as they will be after the current shift, so the final load edge
  // can seed Q from the freshly completed configuration.
  always_comb begin
    init_next = '0;
    for (int i = 0; i < N_BLE; i++) begin
      init_next[i] = sr_next[i*W + OFS_INIT];
    end
  end

  // LUT read. FBSEL swaps the top LUT input for the BLE's own Q.
  always_comb begin
    logic [LUT_K-1:0] idx;
    logic [LUT_N-1:0] tbl;
    lut = '0;
    idx = '0;
    tbl = '0;
    for (int i = 0; i < N_BLE; i++) begin
      tbl = cfg_sr[i*W +: LUT_N];
      idx = bus.I[i*LUT_K +: LUT_K];
      if (cfg_sr[i*W + OFS_FBSEL]) begin
        idx[LUT_K-1] = q[i];
      end
      lut[i] = tbl[idx];
    end
  end

  always_ff @(posedge K or negedge RSTN) begin
    if (!RSTN) begin
      state  <= UNCFG;
      cfg_sr <= '0;
      count  <= '0;
      q      <= '0;
    end else if (bus.CFG_EN) begin
      cfg_sr <= sr_next;
      case (state)
        UNCFG: begin
          state <= LOADING;
          count <= CW'(1);
        end
        LOADING: begin
          if (count == CW'(CFG_BITS - 1)) begin
            state <= CONFIGURED;
            count <= CW'(CFG_BITS);
            q     <= init_next;
          end else begin
            count <= count + CW'(1);
          end
        end
        CONFIGURED: begin
          // Reconfiguration: this edge is already the first shift of a new load.
          state <= LOADING;
          count <= CW'(1);
        end
        default: begin
          state <= UNCFG;
          count <= '0;
        end
      endcase
    end else if (state == CONFIGURED) begin
      q <= lut;
    end
  end

`ifdef CLB_LATCH_EN
  logic [N_BLE-1:0] q_lat;

  always_latch begin
    if (!RSTN) begin
      q_lat = '0;
    end else if (K && state == CONFIGURED) begin
      q_lat = lut;
    end
  end

  always_comb begin
    q_eff = q;
    for (int i = 0; i < N_BLE; i++) begin
      if (cfg_sr[i*W + OFS_LATCH]) begin
        q_eff[i] = q_lat[i];
      end
    end
  end
`else
  assign q_eff = q;
`endif

  always_comb begin
    bus.X = '0;
    if (state == CONFIGURED) begin
      for (int i = 0; i < N_BLE; i++) begin
        bus.X[i] = cfg_sr[i*W + OFS_OUTSEL] ? q_eff[i] : lut[i];
      end
    end
  end

  assign bus.CFG_DONE = (state == CONFIGURED);
  assign bus.CFG_DOUT = cfg_sr[0];
  assign bus.state    = state;
endmodule

// File: tb/tb_clb_param.sv
// tb_clb_param: self-checking bench for clb_param (N_BLE=2, LUT_K=4).
// A behavioural model tracks the loaded bitstream, load progress and Q bits;
// a queue of shifted-in bits gives the expected CFG_DOUT stream.
module tb_clb_param;
  localparam int N_BLE    = 2;
  localparam int LUT_K    = 4;
  localparam int W        = 20;
  localparam int CFG_BITS = 40;

  // ---------------- clock / reset ----------------
  logic K = 1'b0;
  logic RSTN;
  always #5 K = ~K;

  clb_param_if #(.N_BLE(N_BLE), .LUT_K(LUT_K)) bus ();

  clb_param #(.N_BLE(N_BLE), .LUT_K(LUT_K)) dut (
    .K    (K),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [CFG_BITS-1:0] m_sr;
  int                  m_cnt;
  bit                  m_done;
  logic [N_BLE-1:0]    m_q;
  logic                exp_q[$];

  function automatic logic m_lut(int i, logic [7:0] iv);
    int a;
    a = (int'(iv) >> (i * LUT_K)) & 15;
    if (m_sr[i*W + 17]) begin
      if (m_q[i]) a = a | 8;
      else        a = a & 7;
    end
    return m_sr[i*W + a];
  endfunction

  function automatic logic [N_BLE-1:0] m_x(logic [7:0] iv);
    logic [N_BLE-1:0] r;
    r = '0;
    if (m_done) begin
      for (int i = 0; i < N_BLE; i++) begin
        r[i] = m_sr[i*W + 16] ? m_q[i] : m_lut(i, iv);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_sr   = '0;
    m_cnt  = 0;
    m_done = 0;
    m_q    = '0;
    exp_q.delete();
    repeat (CFG_BITS) exp_q.push_back(1'b0);
  endtask

  task automatic model_edge(input logic en, input logic din, input logic [7:0] iv);
    logic [N_BLE-1:0] nl;
    for (int i = 0; i < N_BLE; i++) nl[i] = m_lut(i, iv);
    if (en) begin
      m_sr = {din, m_sr[CFG_BITS-1:1]};
      exp_q.push_back(din);
      void'(exp_q.pop_front());
      if (m_done) begin
        m_done = 0;
        m_cnt  = 1;
      end else begin
        m_cnt++;
        if (m_cnt == CFG_BITS) begin
          m_done = 1;
          for (int i = 0; i < N_BLE; i++) m_q[i] = m_sr[i*W + 18];
        end
      end
    end else if (m_done) begin
      m_q = nl;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] iv);
    chk({tag, "_x"},    32'(bus.X),        32'(m_x(iv)));
    chk({tag, "_done"}, 32'(bus.CFG_DONE), 32'(m_done));
    chk({tag, "_dout"}, 32'(bus.CFG_DOUT), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input string tag, input logic en, input logic din, input logic [7:0] iv);
    @(negedge K);
    bus.CFG_EN  = en;
    bus.CFG_DIN = din;
    bus.I       = iv;
    #1;
    check_outs(tag, iv);
  endtask

  task automatic edge_();
    @(posedge K);
    model_edge(bus.CFG_EN, bus.CFG_DIN, bus.I);
  endtask

  task automatic step(input string tag, input logic en, input logic din, input logic [7:0] iv);
    drive(tag, en, din, iv);
    edge_();
  endtask

  task automatic do_reset();
    @(negedge K);
    bus.CFG_EN  = 1'b1;
    bus.CFG_DIN = 1'b1;
    RSTN        = 1'b0;
    model_reset();
    #1;
    check_outs("rst_async", bus.I);
    @(posedge K);
    #1;
    check_outs("rst_hold", bus.I);
    @(negedge K);
    bus.CFG_EN = 1'b0;
    RSTN       = 1'b1;
  endtask

  task automatic load(input string tag, input logic [CFG_BITS-1:0] cfg);
    for (int k = 0; k < CFG_BITS; k++) step(tag, 1'b1, cfg[k], 8'($urandom));
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  function automatic logic [W-1:0] ble(logic [15:0] t, bit outsel, bit fb, bit init);
    return {1'b0, init, fb, outsel, t};
  endfunction

  function automatic logic [CFG_BITS-1:0] rand_cfg();
    logic [CFG_BITS-1:0] c;
    c = {8'($urandom), 32'($urandom)};
    c[19] = 1'b0;
    c[39] = 1'b0;
    return c;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [CFG_BITS-1:0] cfg;
    logic [CFG_BITS-1:0] cfg2;
    RSTN        = 1'b1;
    bus.CFG_EN  = 1'b0;
    bus.CFG_DIN = 1'b0;
    bus.I       = '0;
    model_reset();
    do_reset();

    // 39 shifts leave the block unconfigured; the 40th completes it.
    cfg = rand_cfg();
    for (int k = 0; k < CFG_BITS - 1; k++) step("shift", 1'b1, cfg[k], 8'($urandom));
    #1;
    chk("pre40_done", 32'(bus.CFG_DONE), 32'd0);
    chk("pre40_x",    32'(bus.X),        32'd0);
    step("shift40", 1'b1, cfg[CFG_BITS-1], 8'($urandom));
    #1;
    chk("at40_done", 32'(bus.CFG_DONE), 32'd1);
    idle("rand0", 6);

    // AND4 combinational on BLE0, XOR4 registered on BLE1.
    cfg = {ble(16'h6996, 1, 0, 0), ble(16'h8000, 0, 0, 0)};
    load("ldA", cfg);
    drive("combA", 1'b0, 1'b0, 8'h0F);
    chk("lut_comb_x0", 32'(bus.X[0]), 32'd1);
    edge_();
    drive("ffA", 1'b0, 1'b0, 8'h70);
    edge_();
    #1;
    chk("ff_x1", 32'(bus.X[1]), 32'd1);
    chk("ff_x0", 32'(bus.X[0]), 32'd0);
    idle("randA", 8);

    // Feedback toggle on BLE0.
    cfg = {ble(16'($urandom), 0, 0, 0), ble(16'h00FF, 1, 1, 0)};
    load("ldT", cfg);
    for (int k = 0; k < 4; k++) begin
      drive("tog", 1'b0, 1'b0, 8'($urandom));
      chk($sformatf("toggle%0d", k), 32'(bus.X[0]), 32'(k % 2));
      edge_();
    end

    // Pause at count 17 for 5 cycles, then finish the load.
    cfg = rand_cfg();
    for (int k = 0; k < 17; k++) step("ldP", 1'b1, cfg[k], 8'($urandom));
    idle("pause", 5);
    #1;
    chk("pause_done", 32'(bus.CFG_DONE), 32'd0);
    for (int k = 17; k < CFG_BITS; k++) step("ldP", 1'b1, cfg[k], 8'($urandom));
    #1;
    chk("resume_done", 32'(bus.CFG_DONE), 32'd1);
    idle("randP", 10);

    // Reset in the middle of a load, then a fresh load.
    cfg = rand_cfg();
    for (int k = 0; k < 30; k++) step("ldR", 1'b1, cfg[k], 8'($urandom));
    do_reset();
    chk("midrst_x", 32'(bus.X), 32'd0);
    cfg = rand_cfg();
    load("ldR2", cfg);
    idle("randR", 8);

    // Daisy-chain replay and reconfiguration.
    cfg  = rand_cfg();
    cfg2 = rand_cfg();
    load("ldD1", cfg);
    for (int k = 0; k < CFG_BITS; k++) begin
      drive("ldD2", 1'b1, cfg2[k], 8'($urandom));
      chk($sformatf("replay%0d", k), 32'(bus.CFG_DOUT), 32'(cfg[k]));
      if (k > 0) chk($sformatf("reconf_done%0d", k), 32'(bus.CFG_DONE), 32'd0);
      edge_();
    end
    idle("randD", 8);

    // Random configurations with random input traffic.
    for (int r = 0; r < 4; r++) begin
      load("ldX", rand_cfg());
      idle("randX", 12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
